// File: rtl/safety_pkg.sv
// ---------------------------------------------------------------------------
// safety_pkg
// Shared types and default constants for the safety light controller.
//   blink_state_t : encoding of the blinker FSM, which also drives the
//                   external blink_state output directly.
//   DEF_*         : default values for the top-level parameters.
//   IN_*          : bit positions of each raw input in the packed input
//                   vector that feeds the per-input debounce instances.
// ---------------------------------------------------------------------------
package safety_pkg;

  typedef enum logic [1:0] {
    BS_OFF    = 2'd0,
    BS_LEFT   = 2'd1,
    BS_RIGHT  = 2'd2,
    BS_HAZARD = 2'd3
  } blink_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_BLINK_HALF      = 25000000;
  localparam int DEF_AUTO_CANCEL     = 0;
  localparam int DEF_PWM_BITS        = 8;
  localparam int DEF_TAIL_DUTY       = 64;

  // Packed input vector layout. Buttons occupy the low bits so that the
  // levels/rises that go unused form contiguous slices.
  localparam int IN_LEFT    = 0;
  localparam int IN_RIGHT   = 1;
  localparam int IN_HAZARD  = 2;
  localparam int IN_HEAD    = 3;
  localparam int IN_BRAKE   = 4;
  localparam int NUM_INPUTS = 5;

endpackage

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
// Two-flop synchroniser followed by a consecutive-cycle debouncer and a
// rising-edge pulse generator for one raw asynchronous input.
//   i_clk      : clock, rising edge
//   i_reset_n  : synchronous active-low reset
//   i_raw      : raw asynchronous input
//   o_level    : debounced level
//   o_rise     : one-cycle pulse, high in the first cycle o_level reads 1
// Parameter DEBOUNCE_CYCLES (>= 1): number of consecutive cycles the
// synchronised input must differ from o_level before o_level follows it.
// ---------------------------------------------------------------------------
module debounce_sync
  import safety_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_sync2 != r_level);
  // The count reaches CNT_LAST on the DEBOUNCE_CYCLES-th consecutive
  // differing cycle, so the new level is taken on that same edge.
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        // Any return to the accepted level restarts the qualification.
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Registered alongside r_level so the pulse lines up with the
      // first cycle of the new high level.
      r_rise <= w_accept && r_sync2;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/safety_light_controller.sv
// ---------------------------------------------------------------------------
// safety_light_controller
// Turn-signal / hazard / headlight / brake lamp controller.
//   CLOCK_50    : clock, all logic on the rising edge
//   reset_n     : synchronous active-low reset
//   left_btn, right_btn, hazard_btn, head_btn : raw buttons, active-high
//   brake_in    : raw brake switch, active-high
//   left_out, right_out : blinker lamp drives
//   head_out    : headlight, toggled by each head button press
//   brake_out   : brake lamp; solid while braking, otherwise dim tail PWM
//                 while the headlight is on
//   blink_state : blinker FSM state (OFF=0, LEFT=1, RIGHT=2, HAZARD=3)
// ---------------------------------------------------------------------------
module safety_light_controller
  import safety_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLINK_HALF      = DEF_BLINK_HALF,
  parameter int AUTO_CANCEL     = DEF_AUTO_CANCEL,
  parameter int PWM_BITS        = DEF_PWM_BITS,
  parameter int TAIL_DUTY       = DEF_TAIL_DUTY
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       left_btn,
  input  logic       right_btn,
  input  logic       hazard_btn,
  input  logic       head_btn,
  input  logic       brake_in,
  output logic       left_out,
  output logic       right_out,
  output logic       head_out,
  output logic       brake_out,
  output logic [1:0] blink_state
);

  // Phase counter runs 0..BLINK_HALF-1 within each half period.
  localparam int                PH_W       = $clog2(BLINK_HALF + 1);
  localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(BLINK_HALF - 1);
  // Completed-period counter for auto-cancel; at least one bit wide even
  // when auto-cancel is disabled.
  localparam int                AC_W       = (AUTO_CANCEL > 1) ? $clog2(AUTO_CANCEL) : 1;
  localparam logic [AC_W-1:0]   AC_LAST    = AC_W'((AUTO_CANCEL > 0) ? AUTO_CANCEL - 1 : 0);
  localparam logic [PWM_BITS-1:0] TAIL_LVL = PWM_BITS'(TAIL_DUTY);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [NUM_INPUTS-1:0] w_raw;
  logic [NUM_INPUTS-1:0] w_level;
  logic [NUM_INPUTS-1:0] w_rise;

  assign w_raw[IN_LEFT]   = left_btn;
  assign w_raw[IN_RIGHT]  = right_btn;
  assign w_raw[IN_HAZARD] = hazard_btn;
  assign w_raw[IN_HEAD]   = head_btn;
  assign w_raw[IN_BRAKE]  = brake_in;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk     (CLOCK_50),
      .i_reset_n (reset_n),
      .i_raw     (w_raw[gi]),
      .o_level   (w_level[gi]),
      .o_rise    (w_rise[gi])
    );
  end

  // Buttons are edge-driven and the brake is level-driven, so half of the
  // conditioned signals have no consumer.
  logic w_unused_cond;
  assign w_unused_cond = ^{w_level[IN_HEAD:IN_LEFT], w_rise[IN_BRAKE]};

  logic w_left_rise;
  logic w_right_rise;
  logic w_haz_rise;
  logic w_brake_lvl;

  assign w_left_rise  = w_rise[IN_LEFT];
  assign w_right_rise = w_rise[IN_RIGHT];
  assign w_haz_rise   = w_rise[IN_HAZARD];
  assign w_brake_lvl  = w_level[IN_BRAKE];

  // -------------------------------------------------------------------------
  // Blinker FSM
  // -------------------------------------------------------------------------
  blink_state_t    r_state;
  blink_state_t    w_state_next;
  logic [PH_W-1:0] r_phase_cnt;
  logic            r_phase_on;
  logic [AC_W-1:0] r_cycle_cnt;

  logic w_half_end;
  logic w_cancel;
  logic w_restart;

  assign w_half_end = (r_phase_cnt == PHASE_LAST);
  // Fires on the last cycle of the final off-phase before auto-cancel.
  assign w_cancel   = (AUTO_CANCEL > 0) && !r_phase_on && w_half_end &&
                      (r_cycle_cnt == AC_LAST);
  assign w_restart  = (w_state_next != r_state) && (w_state_next != BS_OFF);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= BS_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A hazard press dominates everything; left and right
  // pressed in the same cycle cancel each other out.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      BS_OFF: begin
        if (w_haz_rise)                        w_state_next = BS_HAZARD;
        else if (w_left_rise && !w_right_rise) w_state_next = BS_LEFT;
        else if (w_right_rise && !w_left_rise) w_state_next = BS_RIGHT;
      end
      BS_LEFT: begin
        if (w_haz_rise)                        w_state_next = BS_HAZARD;
        else if (w_left_rise && !w_right_rise) w_state_next = BS_OFF;
        else if (w_right_rise && !w_left_rise) w_state_next = BS_RIGHT;
        else if (w_cancel)                     w_state_next = BS_OFF;
      end
      BS_RIGHT: begin
        if (w_haz_rise)                        w_state_next = BS_HAZARD;
        else if (w_right_rise && !w_left_rise) w_state_next = BS_OFF;
        else if (w_left_rise && !w_right_rise) w_state_next = BS_LEFT;
        else if (w_cancel)                     w_state_next = BS_OFF;
      end
      BS_HAZARD: begin
        if (w_haz_rise) w_state_next = BS_OFF;
      end
      default: w_state_next = BS_OFF;
    endcase
  end

  // Blink phase timer. Entering an active state starts a fresh on-phase so
  // the lamp lights for a full half period from the first active cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_phase_cnt <= '0;
      r_phase_on  <= 1'b0;
      r_cycle_cnt <= '0;
    end else if (w_restart) begin
      r_phase_cnt <= '0;
      r_phase_on  <= 1'b1;
      r_cycle_cnt <= '0;
    end else if (r_state == BS_OFF) begin
      r_phase_cnt <= '0;
      r_phase_on  <= 1'b0;
      r_cycle_cnt <= '0;
    end else if (w_half_end) begin
      r_phase_cnt <= '0;
      r_phase_on  <= !r_phase_on;
      // One full period completes at the end of each off-phase.
      if (!r_phase_on) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
    end else begin
      r_phase_cnt <= r_phase_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Headlight toggle and tail PWM
  // -------------------------------------------------------------------------
  logic                r_head_on;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_head_on <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      if (w_rise[IN_HEAD]) begin
        r_head_on <= !r_head_on;
      end
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    left_out    = 1'b0;
    right_out   = 1'b0;
    blink_state = r_state;
    unique case (r_state)
      BS_LEFT:   left_out = r_phase_on;
      BS_RIGHT:  right_out = r_phase_on;
      BS_HAZARD: begin
        left_out  = r_phase_on;
        right_out = r_phase_on;
      end
      default: begin
        left_out  = 1'b0;
        right_out = 1'b0;
      end
    endcase
    head_out = r_head_on;
    // TAIL_LVL of zero makes the compare never true, giving a dark tail.
    if (w_brake_lvl) begin
      brake_out = 1'b1;
    end else begin
      brake_out = r_head_on && (r_pwm_cnt < TAIL_LVL);
    end
  end

endmodule

// File: tb/tb_safety_light_controller.sv
module tb_safety_light_controller;

  localparam int DB  = 4;
  localparam int BH  = 8;
  localparam int PWB = 4;
  localparam int TD  = 4;
  localparam int AC  = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       left_btn = 1'b0;
  logic       right_btn = 1'b0;
  logic       hazard_btn = 1'b0;
  logic       head_btn = 1'b0;
  logic       brake_in = 1'b0;
  logic       left_out;
  logic       right_out;
  logic       head_out;
  logic       brake_out;
  logic [1:0] blink_state;

  always #5 CLOCK_50 = ~CLOCK_50;

  safety_light_controller #(
    .DEBOUNCE_CYCLES(DB),
    .BLINK_HALF(BH),
    .AUTO_CANCEL(AC),
    .PWM_BITS(PWB),
    .TAIL_DUTY(TD)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .left_btn    (left_btn),
    .right_btn   (right_btn),
    .hazard_btn  (hazard_btn),
    .head_btn    (head_btn),
    .brake_in    (brake_in),
    .left_out    (left_out),
    .right_out   (right_out),
    .head_out    (head_out),
    .brake_out   (brake_out),
    .blink_state (blink_state)
  );

  // Observed vector layout: {blink_state, left, right, head, brake}
  typedef struct {
    int         cyc;
    logic [5:0] val;
    logic [5:0] mask;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   rel_cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Expectations are kept ordered by cycle so the monitor only looks at
  // the head of the queue.
  task automatic push_exp(input int d, input string nm, input logic [5:0] v,
                          input logic [5:0] m);
    exp_t e;
    int   i;
    e.cyc  = cyc + d;
    e.val  = v;
    e.mask = m;
    e.name = nm;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > e.cyc) i--;
    exp_q.insert(i, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Tail PWM level at cycle k: counter restarted from 0 at the last reset release.
  function automatic logic pwm_on(input int k);
    return ((k - rel_cyc) % (1 << PWB)) < TD;
  endfunction

  function automatic logic blink_on(input int since_entry);
    return (since_entry % (2 * BH)) < BH;
  endfunction

  // Monitor: sample outputs mid-cycle and retire every expectation due now.
  always @(negedge CLOCK_50) begin : mon
    exp_t       e;
    logic [5:0] obs;
    obs = {blink_state, left_out, right_out, head_out, brake_out};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s missed: due cyc=%0d seen cyc=%0d", e.name, e.cyc, cyc);
      end else if ((obs & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, obs, e.val, e.mask);
      end else begin
        $display("ok   %s cyc=%0d out=%b", e.name, cyc, obs);
      end
    end
  end

  initial begin
    // ---- reset state ----
    @(negedge CLOCK_50);
    push_exp(1, "reset_state", 6'b000000, 6'h3F);
    push_exp(2, "reset_state", 6'b000000, 6'h3F);
    tick(3);
    reset_n = 1'b1;
    rel_cyc = cyc;
    for (int d = 1; d <= 6; d++) push_exp(d, "release_quiet", 6'b000000, 6'h3F);
    tick(8);

    // ---- short glitch on left: three cycles is below the debounce count ----
    left_btn = 1'b1;
    for (int d = 1; d <= 16; d++) push_exp(d, "glitch_no_rise", 6'b000000, 6'h3F);
    tick(3);
    left_btn = 1'b0;
    tick(14);

    // ---- left press: enter LEFT, two full periods, auto-cancel ----
    left_btn = 1'b1;
    for (int d = 6; d <= 40; d++) begin
      logic [1:0] bs;
      logic       on;
      bs = (d >= 7 && d <= 38) ? 2'd1 : 2'd0;
      on = (bs == 2'd1) && blink_on(d - 7);
      push_exp(d, "left_autocancel", {bs, on, 1'b0, 1'b0, 1'b0}, 6'h3F);
    end
    tick(10);
    left_btn = 1'b0;
    tick(35);

    // ---- LEFT, then hazard+right together: hazard wins, phase restarts ----
    left_btn = 1'b1;
    for (int d = 6; d <= 17; d++) begin
      logic [1:0] bs;
      logic       on;
      bs = (d >= 7) ? 2'd1 : 2'd0;
      on = (d >= 7) && blink_on(d - 7);
      push_exp(d, "left_enter", {bs, on, 1'b0, 1'b0, 1'b0}, 6'h3F);
    end
    tick(10);
    left_btn = 1'b0;
    tick(2);
    hazard_btn = 1'b1;
    right_btn  = 1'b1;
    for (int d = 6; d <= 50; d++) begin
      logic on;
      if (d == 6) begin
        push_exp(d, "left_before_haz", 6'b010000, 6'h3F);
      end else begin
        on = blink_on(d - 7);
        push_exp(d, "hazard_blink", {2'd3, on, on, 1'b0, 1'b0}, 6'h3F);
      end
    end
    tick(10);
    hazard_btn = 1'b0;
    right_btn  = 1'b0;
    tick(40);
    hazard_btn = 1'b1;
    push_exp(6, "hazard_hold", 6'b110000, 6'b110000);
    for (int d = 7; d <= 12; d++) push_exp(d, "hazard_off", 6'b000000, 6'h3F);
    tick(10);
    hazard_btn = 1'b0;
    tick(15);

    // ---- headlight on: tail PWM 4 of 16 ----
    head_btn = 1'b1;
    push_exp(6, "head_pre", 6'b000000, 6'h3F);
    for (int d = 7; d <= 40; d++)
      push_exp(d, "tail_pwm", {2'd0, 1'b0, 1'b0, 1'b1, pwm_on(cyc + d)}, 6'h3F);
    tick(10);
    head_btn = 1'b0;
    tick(30);

    // ---- brake overrides tail, then tail resumes ----
    brake_in = 1'b1;
    for (int d = 1; d <= 45; d++) begin
      logic b;
      b = (d >= 6 && d <= 25) ? 1'b1 : pwm_on(cyc + d);
      push_exp(d, "brake", {2'd0, 1'b0, 1'b0, 1'b1, b}, 6'h3F);
    end
    tick(20);
    brake_in = 1'b0;
    tick(26);

    // ---- reset for one cycle mid-HAZARD with head on ----
    hazard_btn = 1'b1;
    push_exp(6, "haz_pre", 6'b000010, 6'b110010);
    for (int d = 7; d <= 11; d++) push_exp(d, "haz_head", 6'b111110, 6'b111110);
    tick(10);
    hazard_btn = 1'b0;
    tick(2);
    reset_n = 1'b0;
    for (int d = 1; d <= 6; d++) push_exp(d, "reset_abort", 6'b000000, 6'h3F);
    tick(1);
    reset_n = 1'b1;
    rel_cyc = cyc;
    tick(8);

    // every expectation must have been retired by the monitor
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expectations left=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/safety_light_controller.md
SAFETY_LIGHT_CONTROLLER -- requirements
Module: safety_light_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept an input level (min 1).
REQ-002 SHALL have parameter BLINK_HALF, default 25000000, meaning cycles per blinker on-phase and per off-phase (min 1).
REQ-003 SHALL have parameter AUTO_CANCEL, default 0, meaning full blink periods before LEFT/RIGHT auto-returns to OFF; 0 disables.
REQ-004 SHALL have parameter PWM_BITS, default 8, meaning brake/tail PWM counter width.
REQ-005 SHALL have parameter TAIL_DUTY, default 64, meaning tail-light duty count, range 0..2^PWM_BITS-1.
REQ-006 SHALL have port CLOCK_50, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit, meaning synchronous active-low reset.
REQ-008 SHALL have ports left_btn, right_btn, hazard_btn and head_btn, each input, 1 bit, meaning raw asynchronous buttons, active-high.
REQ-009 SHALL have port brake_in, input, 1 bit, meaning raw brake switch, active-high, debounced like the buttons.
REQ-010 SHALL have ports left_out, right_out, head_out and brake_out, each output, 1 bit, meaning lamp drives.
REQ-011 SHALL have port blink_state, output, 2 bits, meaning current blinker FSM state encoded per REQ-016.

Function
REQ-012 Every raw input SHALL pass a 2-flop synchroniser, then a debouncer.
REQ-013 Debounced level SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any interruption reloads the count.
REQ-014 A one-cycle rise pulse SHALL be generated on each debounced 0->1 transition of left, right, hazard and head.
REQ-015 head_out SHALL toggle on each head rise pulse.
REQ-016 Blinker FSM states: OFF=0, LEFT=1, RIGHT=2, HAZARD=3.
REQ-017 Transitions from OFF SHALL be: left rise -> LEFT; right rise -> RIGHT; hazard rise -> HAZARD.
REQ-018 Transitions from LEFT SHALL be: left rise -> OFF; right rise -> RIGHT; hazard rise -> HAZARD. RIGHT SHALL mirror LEFT.
REQ-019 In HAZARD, hazard rise SHALL go to OFF; left/right rises SHALL be ignored.
REQ-020 Simultaneous rises: hazard SHALL win; left+right together without hazard SHALL be ignored (state held).
REQ-021 On every state change into LEFT, RIGHT or HAZARD, the phase counter SHALL restart so the lamp is on for exactly BLINK_HALF cycles starting the cycle after the transition, then off for BLINK_HALF, repeating.
REQ-022 In LEFT, left_out SHALL equal the phase and right_out SHALL be 0; RIGHT is the mirror; HAZARD SHALL drive both with the phase; OFF SHALL drive both 0.
REQ-023 With AUTO_CANCEL=N>0, LEFT/RIGHT SHALL return to OFF at the end of the Nth off-phase; HAZARD SHALL never auto-cancel.
REQ-024 PWM counter SHALL be free-running PWM_BITS wide, wrapping 2^PWM_BITS-1 -> 0.
REQ-025 brake_out SHALL be constant 1 while debounced brake is 1.
REQ-026 Otherwise, if head_out=1, brake_out SHALL be (pwm_cnt < TAIL_DUTY); if head_out=0, 0.
REQ-027 TAIL_DUTY=0 SHALL give constant 0 tail.

Reset
REQ-028 While reset_n=0 at a clock edge: synchronisers and debounced levels SHALL be 0, debounce/phase/cycle/PWM counters SHALL be 0, FSM OFF, and all outputs 0.
REQ-029 Reset asserted mid-blink or mid-debounce SHALL abort the operation; no rise pulse SHALL be generated by reset release with inputs low.

Structure
REQ-030 Package safety_pkg SHALL hold the blink_state_t enum and the default parameter constants.
REQ-031 Sub-module debounce_sync (synchroniser + debouncer + rise pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per input via generate.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF=8, PWM_BITS=4, TAIL_DUTY=4, AUTO_CANCEL=2)
REQ-032 left_btn high 3 cycles then low -> no rise, blink_state stays 0; held high 10 cycles -> blink_state=1 at sync+4 cycles, left_out high 8 cycles, low 8.
REQ-033 LEFT active, no further input -> exactly 2 on/off periods (32 cycles), then blink_state=0, left_out=0.
REQ-034 LEFT active, hazard and right rise same cycle -> blink_state=3, both outputs in phase, phase restarted; hazard rise again -> OFF.
REQ-035 head rise -> head_out=1, brake_out high 4 of every 16 cycles; brake_in high -> brake_out constant 1; brake released -> 4/16 resumes.
REQ-036 Reset asserted for 1 cycle mid-HAZARD with head_out=1 -> next cycle all outputs 0, blink_state=0.
